// File: rtl/alsu_result_display_if.sv
`default_nettype none
// alsu_result_display_if: ALSU result/LED inputs and seven-segment outputs -- rev 1.0
interface alsu_result_display_if;
   logic [5:0]  alsu_out;
   logic [15:0] alsu_leds;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        busy;

   modport master (output alsu_out, alsu_leds, input seg, dp, an, busy);
   modport slave  (input alsu_out, alsu_leds, output seg, dp, an, busy);
endinterface
`default_nettype wire

// File: rtl/alsu_result_display.sv
`default_nettype none
// alsu_result_display: ALSU result on a 4-digit 7-seg (hex + decimal), blinking "Err" on invalid ops -- rev 1.0
module alsu_result_display #(
   parameter int REFRESH_DIV  = 50000,
   parameter int BLINK_FRAMES = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   alsu_result_display_if.slave bus
);

   localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam int BW = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [CW-1:0] REF_MAX   = CW'(REFRESH_DIV - 1);
   localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_FRAMES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      LOAD = 2'd2
   } state_t;

   state_t      state;
   logic [5:0]  cap_val;
   logic        cap_err;
   logic [5:0]  bin;
   logic [3:0]  tens;
   logic [3:0]  units;
   logic [2:0]  iter;
   logic        busy_q;

   logic [1:0]  hex_hi;
   logic [3:0]  hex_lo;
   logic [3:0]  dec_tens;
   logic [3:0]  dec_units;
   logic        disp_err;

   logic [CW-1:0] refresh_cnt;
   logic [1:0]    idx;
   logic [BW-1:0] blink_cnt;
   logic          blink_on;
   logic [3:0]    an_q;
   logic [6:0]    seg_q;

   logic        err;
   logic [3:0]  tens_adj;
   logic [3:0]  units_adj;
   logic        ref_wrap;
   logic        frame_end;
   logic [3:0]  nib;
   logic [6:0]  pattern;

   function automatic logic [6:0] hex_seg(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   assign err       = |bus.alsu_leds;
   assign tens_adj  = (tens  >= 4'd5) ? tens  + 4'd3 : tens;
   assign units_adj = (units >= 4'd5) ? units + 4'd3 : units;

   // Capture / double-dabble FSM: one binary bit shifted into the BCD pair per clock
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cap_val   <= 6'd0;
         cap_err   <= 1'b0;
         bin       <= 6'd0;
         tens      <= 4'd0;
         units     <= 4'd0;
         iter      <= 3'd0;
         busy_q    <= 1'b0;
         hex_hi    <= 2'd0;
         hex_lo    <= 4'd0;
         dec_tens  <= 4'd0;
         dec_units <= 4'd0;
         disp_err  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if ({bus.alsu_out, err} != {cap_val, cap_err}) begin
                  cap_val <= bus.alsu_out;
                  cap_err <= err;
                  bin     <= bus.alsu_out;
                  tens    <= 4'd0;
                  units   <= 4'd0;
                  iter    <= 3'd0;
                  busy_q  <= 1'b1;
                  state   <= CONV;
               end
            end
            CONV: begin
               tens  <= {tens_adj[2:0], units_adj[3]};
               units <= {units_adj[2:0], bin[5]};
               bin   <= {bin[4:0], 1'b0};
               iter  <= iter + 3'd1;
               if (iter == 3'd5) begin
                  state <= LOAD;
               end
            end
            LOAD: begin
               hex_hi    <= cap_val[5:4];
               hex_lo    <= cap_val[3:0];
               dec_tens  <= tens;
               dec_units <= units;
               disp_err  <= cap_err;
               busy_q    <= 1'b0;
               state     <= IDLE;
            end
            default: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign ref_wrap  = (refresh_cnt == REF_MAX);
   assign frame_end = ref_wrap && (idx == 2'd3);

   always_comb begin
      nib = 4'd0;
      case (idx)
         2'd3:    nib = {2'b00, hex_hi};
         2'd2:    nib = hex_lo;
         2'd1:    nib = dec_tens;
         default: nib = dec_units;
      endcase
      pattern = hex_seg(nib);
      if (disp_err) begin
         if (!blink_on) begin
            pattern = 7'h7F;
         end else begin
            case (idx)
               2'd3:    pattern = 7'h06;
               2'd2:    pattern = 7'h2F;
               2'd1:    pattern = 7'h2F;
               default: pattern = 7'h7F;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         refresh_cnt <= '0;
         idx         <= 2'd0;
         an_q        <= 4'hF;
         seg_q       <= 7'h7F;
         blink_cnt   <= '0;
         blink_on    <= 1'b1;
      end else begin
         refresh_cnt <= ref_wrap ? '0 : refresh_cnt + 1'b1;
         if (ref_wrap) begin
            idx <= idx + 2'd1;
         end
         an_q  <= ~(4'b0001 << idx);
         seg_q <= pattern;
         // Blink state only runs while the error pattern is on screen
         if (!disp_err) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
         end else if (frame_end) begin
            if (blink_cnt == BLINK_MAX) begin
               blink_cnt <= '0;
               blink_on  <= ~blink_on;
            end else begin
               blink_cnt <= blink_cnt + 1'b1;
            end
         end
      end
   end

   assign bus.seg  = seg_q;
   assign bus.an   = an_q;
   assign bus.dp   = 1'b1;
   assign bus.busy = busy_q;

endmodule
`default_nettype wire
